// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared FSM encodings and geometry helpers for cache_sa_wb.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] S_WRITEBACK  = 3'd1;
    localparam logic [STATE_W-1:0] S_REFILL     = 3'd2;
    localparam logic [STATE_W-1:0] S_FLUSH_SCAN = 3'd3;
    localparam logic [STATE_W-1:0] S_FLUSH_WB   = 3'd4;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w - 2;
    endfunction

    function automatic int line_width(input int word_w, input int offset_w);
        return word_w * (2 ** offset_w);
    endfunction

    function automatic int age_width(input int ways);
        return $clog2(ways);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru
// Description : True-LRU age tracking per set; reports the oldest way.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int INDEX_W = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        i_upd_en,
    input  logic [INDEX_W-1:0]          i_upd_set,
    input  logic [age_width(WAYS)-1:0]  i_upd_way,
    input  logic [INDEX_W-1:0]          i_rd_set,
    output logic [age_width(WAYS)-1:0]  o_lru_way
);

    localparam int SETS  = 2 ** INDEX_W;
    localparam int AGE_W = age_width(WAYS);

    logic [AGE_W-1:0] r_age [SETS][WAYS];

    // Touched way becomes youngest; only ways younger than it age by one.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else if (i_upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == i_upd_way) begin
                    r_age[i_upd_set][w] <= '0;
                end else if (r_age[i_upd_set][w] < r_age[i_upd_set][i_upd_way]) begin
                    r_age[i_upd_set][w] <= r_age[i_upd_set][w] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[i_rd_set][w] == AGE_W'(WAYS - 1)) begin
                o_lru_way = AGE_W'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_sa_wb.sv
`default_nettype none
// ============================================================================
// Module      : cache_sa_wb
// Description : N-way set-associative write-back/write-allocate data cache
//               with true-LRU replacement, dirty-line flush and hit/miss stats.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_sa_wb
    import cache_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int WAYS     = 4,
    parameter int INDEX_W  = 1,
    parameter int OFFSET_W = 2,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             req_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic [WORD_W-1:0]                wdata_i,
    output logic [WORD_W-1:0]                rdata_o,
    output logic                             busy_o,
    input  logic                             flush_i,
    output logic                             flush_done_o,
    output logic                             mem_rd_o,
    output logic                             mem_wr_o,
    output logic [ADDR_W-OFFSET_W-3:0]       mem_addr_o,
    output logic [WORD_W*(2**OFFSET_W)-1:0]  mem_wdata_o,
    input  logic [WORD_W*(2**OFFSET_W)-1:0]  mem_rdata_i,
    input  logic                             mem_ack_i,
    output logic [CNT_W-1:0]                 hit_cnt_o,
    output logic [CNT_W-1:0]                 miss_cnt_o
);

    localparam int SETS   = 2 ** INDEX_W;
    localparam int WAY_W  = age_width(WAYS);
    localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_W = line_width(WORD_W, OFFSET_W);
    localparam int FP_W   = INDEX_W + WAY_W;

    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];

    logic [STATE_W-1:0] r_state;
    logic [WAY_W-1:0]   r_victim;
    logic [TAG_W-1:0]   r_miss_tag;
    logic [INDEX_W-1:0] r_miss_index;
    logic [FP_W-1:0]    r_flush_ptr;
    logic               r_flush_done;
    logic               r_replay;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_free;
    logic [WAY_W-1:0]    w_free_way;
    logic [WAY_W-1:0]    w_lru_way;
    logic [WAY_W-1:0]    w_victim;
    logic [LINE_W-1:0]   w_hit_line;
    logic                w_idle;
    logic                w_hit_done;
    logic                w_lru_en;
    logic [INDEX_W-1:0]  w_fs;
    logic [WAY_W-1:0]    w_fw;
    logic                w_flush_last;
    logic                w_unused_addr;

    assign w_tag         = addr_i[ADDR_W-1 -: TAG_W];
    assign w_index       = addr_i[OFFSET_W+2 +: INDEX_W];
    assign w_offset      = addr_i[2 +: OFFSET_W];
    assign w_unused_addr = ^addr_i[1:0];

    assign w_fs         = r_flush_ptr[WAY_W +: INDEX_W];
    assign w_fw         = r_flush_ptr[WAY_W-1:0];
    assign w_flush_last = &r_flush_ptr;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_free     = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
    end

    assign w_victim   = w_free ? w_free_way : w_lru_way;
    assign w_hit_line = r_data[w_index][w_hit_way];
    assign w_idle     = (r_state == S_IDLE);
    assign w_hit_done = w_idle && req_i && !flush_i && w_hit;
    assign w_lru_en   = w_hit_done || ((r_state == S_REFILL) && mem_ack_i);

    cache_lru #(
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W)
    ) u_lru (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .i_upd_en  (w_lru_en),
        .i_upd_set (w_hit_done ? w_index : r_miss_index),
        .i_upd_way (w_hit_done ? w_hit_way : r_victim),
        .i_rd_set  (w_index),
        .o_lru_way (w_lru_way)
    );

    assign rdata_o      = w_hit ? w_hit_line[int'(w_offset)*WORD_W +: WORD_W] : '0;
    assign busy_o       = !w_idle || (req_i && !w_hit_done);
    assign flush_done_o = r_flush_done;
    assign mem_rd_o     = (r_state == S_REFILL);
    assign mem_wr_o     = (r_state == S_WRITEBACK) || (r_state == S_FLUSH_WB);
    assign hit_cnt_o    = r_hit_cnt;
    assign miss_cnt_o   = r_miss_cnt;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            S_WRITEBACK: begin
                mem_addr_o  = {r_tag[r_miss_index][r_victim], r_miss_index};
                mem_wdata_o = r_data[r_miss_index][r_victim];
            end
            S_REFILL:    mem_addr_o = {r_miss_tag, r_miss_index};
            S_FLUSH_WB: begin
                mem_addr_o  = {r_tag[w_fs][w_fw], w_fs};
                mem_wdata_o = r_data[w_fs][w_fw];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_victim     <= '0;
            r_miss_tag   <= '0;
            r_miss_index <= '0;
            r_flush_ptr  <= '0;
            r_flush_done <= 1'b0;
            r_replay     <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_data[s][w]  <= '0;
                end
            end
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_state     <= S_FLUSH_SCAN;
                        r_flush_ptr <= '0;
                    end else if (req_i && w_hit) begin
                        if (we_i) begin
                            r_data[w_index][w_hit_way][int'(w_offset)*WORD_W +: WORD_W] <= wdata_i;
                            r_dirty[w_index][w_hit_way] <= 1'b1;
                        end
                        // The replayed access after a refill is not a new hit.
                        if (r_replay) begin
                            r_replay <= 1'b0;
                        end else if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        end
                    end else if (req_i) begin
                        r_victim     <= w_victim;
                        r_miss_tag   <= w_tag;
                        r_miss_index <= w_index;
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                        r_state <= (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim])
                                   ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        r_valid[r_miss_index][r_victim] <= 1'b1;
                        r_dirty[r_miss_index][r_victim] <= 1'b0;
                        r_tag[r_miss_index][r_victim]   <= r_miss_tag;
                        r_data[r_miss_index][r_victim]  <= mem_rdata_i;
                        r_replay <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (r_valid[w_fs][w_fw] && r_dirty[w_fs][w_fw]) begin
                        r_state <= S_FLUSH_WB;
                    end else if (w_flush_last) begin
                        r_flush_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_flush_ptr <= r_flush_ptr + FP_W'(1);
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_ack_i) begin
                        r_dirty[w_fs][w_fw] <= 1'b0;
                        if (w_flush_last) begin
                            r_flush_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_flush_ptr <= r_flush_ptr + FP_W'(1);
                            r_state     <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_sa_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_sa_wb
// Description : Scoreboard bench for cache_sa_wb with a fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_sa_wb;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset_ni = 1'b0;
    logic         req_i = 1'b0;
    logic         we_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [31:0]  wdata_i = '0;
    logic         flush_i = 1'b0;
    logic         mem_ack_i = 1'b0;
    logic [127:0] mem_rdata_i = '0;
    logic [31:0]  rdata_o;
    logic         busy_o;
    logic         flush_done_o;
    logic         mem_rd_o;
    logic         mem_wr_o;
    logic [27:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [3:0]   hit_cnt_o;
    logic [3:0]   miss_cnt_o;

    always #5 clk = ~clk;

    cache_sa_wb #(
        .WORD_W(32), .WAYS(4), .INDEX_W(1), .OFFSET_W(2), .ADDR_W(32), .CNT_W(4)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .mem_rd_o     (mem_rd_o),
        .mem_wr_o     (mem_wr_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          stalls;
        int          id;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mem_model [logic [27:0]];
    logic [27:0]  rd_log[$];
    logic [27:0]  wr_log[$];
    logic [127:0] wr_data_log[$];
    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Untouched memory lines hold word k = 0xA0000000 + line_byte_addr + k.
    function automatic logic [127:0] line_init(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA000_0000 + {la, 4'h0} + 32'(k);
        return l;
    endfunction

    initial begin : responder
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack_i = 1'b0;
            if (!reset_ni) begin
                cnt = 0;
            end else if (mem_rd_o || mem_wr_o) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    mem_ack_i = 1'b1;
                    if (mem_rd_o) begin
                        rd_log.push_back(mem_addr_o);
                        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                                   : line_init(mem_addr_o);
                    end else begin
                        wr_log.push_back(mem_addr_o);
                        wr_data_log.push_back(mem_wdata_o);
                        mem_model[mem_addr_o] = mem_wdata_o;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        int stall = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (flush_done_o) done_cnt++;
            if (mem_rd_o || mem_wr_o) chk("rd_wr_exclusive", mem_rd_o & mem_wr_o, 0);
            if (!req_i) begin
                stall = 0;
            end else if (busy_o) begin
                stall++;
            end else if (sb.size() == 0) begin
                chk("unexpected_completion", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("stalls_id%0d", e.id), stall, e.stalls);
                if (!e.we) chk($sformatf("rdata_id%0d", e.id), rdata_o, e.rdata);
                stall = 0;
            end
        end
    end

    int id = 0;
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int stalls);
        exp_t e;
        bit   done = 0;
        id++;
        e.we = we; e.rdata = exp_rd; e.stalls = stalls; e.id = id;
        sb.push_back(e);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
        end
        chk($sformatf("access_done_id%0d", id), done, 1);
        if (!done) void'(sb.pop_back());
        @(posedge clk);
        #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_flush(input int exp_writes, input int exp_delay);
        int wr0 = wr_log.size();
        int d0  = done_cnt;
        int at  = -1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        for (int k = 1; k < 200 && at < 0; k++) begin
            @(negedge clk);
            if (flush_done_o) at = k;
        end
        chk("flush_delay", at, exp_delay);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_pulses", done_cnt - d0, 1);
        chk("flush_writes", wr_log.size() - wr0, exp_writes);
    endtask

    task automatic chk_counters(input string tag, input int h, input int m);
        chk({tag, "_hit_cnt"}, hit_cnt_o, h);
        chk({tag, "_miss_cnt"}, miss_cnt_o, m);
    endtask

    logic [127:0] exp_line;
    int           wr0;

    initial begin : main
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_rd", mem_rd_o, 0);
        chk("rst_mem_wr", mem_wr_o, 0);
        chk("rst_flush_done", flush_done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk_counters("rst", 0, 0);
        @(posedge clk);
        #1;

        // Cold miss then stores/loads on the same line
        access(0, 32'h10, 0, 32'hA000_0010, LAT + 1);
        chk("first_rd_addr", rd_log.size() > 0 ? rd_log[0] : 28'hFFF_FFFF, 28'h1);
        chk_counters("cold", 0, 1);
        access(1, 32'h14, 32'hDEAD_BEEF, 0, 0);
        access(0, 32'h14, 0, 32'hDEAD_BEEF, 0);
        chk_counters("store", 2, 1);
        access(0, 32'h18, 0, 32'hA000_0012, 0);

        // LRU: fill set 0, touch way 0, fifth tag must evict way 1 (0x40)
        access(0, 32'h20, 0, 32'hA000_0020, LAT + 1);
        access(0, 32'h40, 0, 32'hA000_0040, LAT + 1);
        access(0, 32'h60, 0, 32'hA000_0060, LAT + 1);
        access(0, 32'h80, 0, 32'hA000_0080, LAT + 1);
        access(0, 32'h20, 0, 32'hA000_0020, 0);
        access(0, 32'hA0, 0, 32'hA000_00A0, LAT + 1);
        access(0, 32'h20, 0, 32'hA000_0020, 0);
        access(0, 32'h40, 0, 32'hA000_0040, LAT + 1);
        access(0, 32'h80, 0, 32'hA000_0080, 0);
        chk_counters("lru", 6, 7);

        // Dirty 0x80 line, age it to LRU, then evict it
        access(1, 32'h88, 32'hCAFE_F00D, 0, 0);
        access(0, 32'hA0, 0, 32'hA000_00A0, 0);
        access(0, 32'h20, 0, 32'hA000_0020, 0);
        access(0, 32'h40, 0, 32'hA000_0040, 0);
        wr0 = wr_log.size();
        access(0, 32'hC0, 0, 32'hA000_00C0, 2 * LAT + 1);
        chk("evict_wr_count", wr_log.size() - wr0, 1);
        chk("evict_wr_addr", wr_log.size() > 0 ? wr_log[0] : 28'hFFF_FFFF, 28'h8);
        exp_line = line_init(28'h8);
        exp_line[64 +: 32] = 32'hCAFE_F00D;
        chk("evict_wr_data", wr_data_log.size() > 0 ? wr_data_log[0] : '0, exp_line);
        chk("evict_rd_addr", rd_log.size() > 0 ? rd_log[rd_log.size()-1] : 28'hFFF_FFFF, 28'hC);
        chk_counters("evict", 10, 8);

        // Flush: dirty lines at (set0,way0)=line 2 and (set1,way0)=line 1
        access(1, 32'h24, 32'h1234_5678, 0, 0);
        wr0 = wr_log.size();
        do_flush(2, 9 + 2 * LAT);
        chk("flush_addr0", wr_log.size() > wr0 ? wr_log[wr0] : 28'hFFF_FFFF, 28'h2);
        chk("flush_addr1", wr_log.size() > wr0 + 1 ? wr_log[wr0+1] : 28'hFFF_FFFF, 28'h1);
        exp_line = line_init(28'h2);
        exp_line[32 +: 32] = 32'h1234_5678;
        chk("flush_data0", wr_data_log.size() > wr0 ? wr_data_log[wr0] : '0, exp_line);
        exp_line = line_init(28'h1);
        exp_line[32 +: 32] = 32'hDEAD_BEEF;
        chk("flush_data1", wr_data_log.size() > wr0 + 1 ? wr_data_log[wr0+1] : '0, exp_line);
        wr0 = wr_log.size();
        access(0, 32'h24, 0, 32'h1234_5678, 0);
        chk("post_flush_no_wr", wr_log.size() - wr0, 0);
        do_flush(0, 9);

        // Hit counter saturation at 15
        for (int i = 0; i < 5; i++) access(0, 32'h14, 0, 32'hDEAD_BEEF, 0);
        chk_counters("hit_sat", 15, 8);

        // Reset while REFILL is outstanding
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("refill_rd", mem_rd_o, 1);
        chk("refill_addr", mem_addr_o, 28'h30);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        reset_ni = 1'b0;
        @(posedge clk);
        #1 reset_ni = 1'b1;
        @(negedge clk);
        chk("midrst_mem_rd", mem_rd_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_flush_done", flush_done_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        chk_counters("midrst", 0, 0);
        @(posedge clk);
        #1;

        // Everything misses now; flushed data came back from memory
        access(0, 32'h24, 0, 32'h1234_5678, LAT + 1);
        access(0, 32'h14, 0, 32'hDEAD_BEEF, LAT + 1);
        for (int i = 0; i < 14; i++)
            access(0, 32'h1000 + 32'(i) * 16, 0, 32'hA000_1000 + 32'(i) * 16, LAT + 1);
        chk_counters("miss_sat", 0, 15);
        access(0, 32'h10D0, 0, 32'hA000_10D0, 0);
        chk_counters("final", 1, 15);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cache_sa_wb.md
# cache_sa_wb

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement, a dirty-line flush command and hit/miss counters. It sits between the core's load/store port and the block-wide data memory, replacing the fixed 4-way, usage-count cache. It generalises ways, sets and line length, and adds explicit flush and statistics.

## Interface
Parameters:
- WORD_W, 32, CPU word width
- WAYS, 4, associativity (power of two, ≥2)
- INDEX_W, 1, set index bits (2**INDEX_W sets)
- OFFSET_W, 2, word-in-line bits (2**OFFSET_W words per line)
- ADDR_W, 32, byte address width; TAG_W = ADDR_W-INDEX_W-OFFSET_W-2
- CNT_W, 16, statistics counter width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_ni  in  1  synchronous, active-low reset
- req_i  in  1  CPU access request, held until busy_o low
- we_i  in  1  1 = store, 0 = load (valid with req_i)
- addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- wdata_i  in  WORD_W  store data
- rdata_o  out  WORD_W  load data, valid when req_i & !busy_o
- busy_o  out  1  stall CPU
- flush_i  in  1  one-cycle pulse: write back all dirty lines
- flush_done_o  out  1  one-cycle pulse at flush end
- mem_rd_o / mem_wr_o  out  1  line read / write request
- mem_addr_o  out  ADDR_W-OFFSET_W-2  line address ({tag,index})
- mem_wdata_o  out  WORD_W*2**OFFSET_W  victim line
- mem_rdata_i  in  WORD_W*2**OFFSET_W  refill line
- mem_ack_i  in  1  one-cycle transaction-complete pulse
- hit_cnt_o, miss_cnt_o  out  CNT_W  saturating counters

## Operation
- Address split: tag=[ADDR_W-1 : INDEX_W+OFFSET_W+2], index, offset=[OFFSET_W+1:2].
- Hit: any valid way with matching tag (at most one). Load: rdata_o = selected word, combinational. Store: word written at the edge, line dirty=1.
- LRU: per set, one age per way (clog2(WAYS) bits), distinct values. On hit or fill of way w: age[w]←0; every way with age < old age[w] increments. Reset ages: age[w]=w.
- Victim: lowest-index invalid way; otherwise the way with age = WAYS-1.
- States: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE: flush_i → FLUSH_SCAN (flush wins over simultaneous req_i, which stalls). req_i & miss & victim dirty → WRITEBACK. req_i & miss & clean victim → REFILL.
- WRITEBACK: mem_wr_o=1, mem_addr_o={victim tag,index}, mem_wdata_o=victim line. On mem_ack_i → REFILL.
- REFILL: mem_rd_o=1, mem_addr_o={tag,index}. On mem_ack_i: install line, valid=1, dirty=0, tag, LRU update, then → IDLE. The request replays as a hit.
- FLUSH_SCAN: walks (set,way) from (0,0) one entry per cycle. A dirty entry → FLUSH_WB. After the last entry, pulse flush_done_o → IDLE.
- FLUSH_WB: writes back the line. On mem_ack_i: dirty=0 (valid kept), then → FLUSH_SCAN at the next entry. LRU is untouched by flush.
- Counters: miss_cnt++ on the IDLE miss decision. hit_cnt++ on a hit not following a refill (replay flag). Both saturate at all-ones.

## Timing
- busy_o = (state≠IDLE) | (req_i & !hit), combinational. A hit completes with zero wait cycles.
- Clean miss: busy for M+1 cycles (M = memory latency to ack). Dirty miss: M_wr+M_rd+1.
- mem_rd_o / mem_wr_o are held high continuously until the ack cycle and drop the cycle after. Never both high.
- mem_ack_i outside WRITEBACK/REFILL/FLUSH_WB is ignored.
- Reset (reset_ni=0 at an edge), including mid-transaction: state=IDLE; all valid, dirty and data cleared; tags 0; ages = way index; counters 0. Outputs the next cycle: busy_o=0 (req_i low), mem_rd_o=mem_wr_o=0, flush_done_o=0, rdata_o=0. An in-flight memory transaction is abandoned.
- Flush with no dirty lines: flush_done_o pulses 2**INDEX_W*WAYS+1 cycles after flush_i.

## Structure
- cache_pkg: state enum, TAG_W/LINE_W/AGE_W localparams, address-split functions.
- Sub-module cache_lru: per-set age arrays, update on (set,way,en), victim output. Everything else lives in cache_sa_wb.

## Test plan
- Reset, then load 0x0000_0010 with a memory model at ack latency 3 → busy 4 cycles, mem_rd_o with mem_addr_o=0x1, then hit; hit_cnt=0, miss_cnt=1.
- Store 0xDEADBEEF to 0x14 after the fill, then load 0x14 → rdata_o=0xDEADBEEF with no stall, line dirty; hit_cnt=2.
- WAYS=4: fill 5 tags into set 0, touching way 0 before the fifth → way 1 is evicted, not way 0.
- Dirty victim eviction → mem_wr_o with the old tag and line data, then mem_rd_o; the memory model holds the stored word.
- Two dirty lines, then flush_i → exactly two mem_wr_o transactions, flush_done_o one pulse, a subsequent load hits with no write-back.
- reset_ni low during REFILL → next cycle mem_rd_o=0, busy_o=0, all lines miss; counters saturate when preloaded near max (CNT_W=4).
